ascon_hash_sio: RTL and testbench

//  Parametrised serial-in/serial-out shim in front of the masked Ascon hash core (fault-countermeasure top).

---
 rtl/ascon_hash_sio_if.sv | 42 ++++
 rtl/ascon_hash_sio.sv | 162 ++++++++++++++++
 tb/tb_ascon_hash_sio.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_hash_sio_if.sv
// Signal bundle between ascon_hash_sio and its environment: serial input lanes, control,
// parallel core operands/digest and the serial digest output.
interface ascon_hash_sio_if #(
   parameter int Y  = 40,
   parameter int L  = 256,
   parameter int RW = 64,
   parameter int NR = 7,
   parameter int FL = 256,
   parameter int W  = 1
);
   logic             in_valid;
   logic             in_ready;
   logic [3*W-1:0]   msg_in;
   logic [NR*W-1:0]  rnd_in;
   logic [W-1:0]     fault_in;
   logic             start;
   logic             busy;
   logic [Y-1:0]     core_msg;
   logic [Y-1:0]     core_m1;
   logic [Y-1:0]     core_m2;
   logic [NR*RW-1:0] core_rnd;
   logic [FL-1:0]    core_fault;
   logic             core_start;
   logic [L-1:0]     core_hash;
   logic             core_done;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     hash_out;
   logic             out_last;

   modport slave (
      input  in_valid, msg_in, rnd_in, fault_in, start, core_hash, core_done, out_ready,
      output in_ready, busy, core_msg, core_m1, core_m2, core_rnd, core_fault, core_start,
             out_valid, hash_out, out_last
   );

   modport master (
      output in_valid, msg_in, rnd_in, fault_in, start, core_hash, core_done, out_ready,
      input  in_ready, busy, core_msg, core_m1, core_m2, core_rnd, core_fault, core_start,
             out_valid, hash_out, out_last
   );
endinterface

// File: rtl/ascon_hash_sio.sv
// Serial-in/serial-out shim for the masked Ascon hash core: loads operands MSB-first from W-bit
// lanes, pulses core_start, captures the digest on core_done and streams it out LSB slice first.
module ascon_hash_sio #(
   parameter int Y  = 40,
   parameter int L  = 256,
   parameter int RW = 64,
   parameter int NR = 7,
   parameter int FL = 256,
   parameter int W  = 1
) (
   input logic           clk,
   input logic           rst,
   ascon_hash_sio_if.slave bus
);
   localparam int MX1 = (Y > FL) ? Y : FL;
   localparam int MX  = (MX1 > RW) ? MX1 : RW;
   localparam int NB  = MX / W;
   localparam int NO  = L / W;
   localparam int CW  = $clog2(NB + 1);
   localparam int OW  = $clog2(NO + 1);

   localparam logic [1:0] LOAD   = 2'd0;
   localparam logic [1:0] ARMED  = 2'd1;
   localparam logic [1:0] RUN    = 2'd2;
   localparam logic [1:0] UNLOAD = 2'd3;

   localparam logic [CW-1:0] NB_LAST   = CW'(NB - 1);
   localparam logic [CW-1:0] MSG_BEATS = CW'(Y / W);
   localparam logic [CW-1:0] RND_BEATS = CW'(RW / W);
   localparam logic [CW-1:0] FLT_BEATS = CW'(FL / W);
   localparam logic [OW-1:0] OUT_LAST  = OW'(NO - 1);

   generate
      if ((Y % W) != 0 || (L % W) != 0 || (RW % W) != 0 || (FL % W) != 0) begin : g_bad_lane
         $error("ascon_hash_sio: W must divide Y, L, RW and FL");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    beat_q, beat_d;
   logic [OW-1:0]    obeat_q, obeat_d;
   logic [Y-1:0]     msg_q, msg_d;
   logic [Y-1:0]     m1_q, m1_d;
   logic [Y-1:0]     m2_q, m2_d;
   logic [NR*RW-1:0] rnd_q, rnd_d;
   logic [FL-1:0]    fault_q, fault_d;
   logic [L-1:0]     osr_q, osr_d;
   logic             in_ready_q, in_ready_d;
   logic             cstart_q, cstart_d;
   logic             in_fire;
   logic             out_fire;

   // Handshakes: a beat moves on an edge where valid && ready are both high; the producer
   // holds data stable while valid && !ready.
   assign in_fire  = bus.in_valid && in_ready_q;
   assign out_fire = (state_q == UNLOAD) && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      obeat_d  = obeat_q;
      msg_d    = msg_q;
      m1_d     = m1_q;
      m2_d     = m2_q;
      rnd_d    = rnd_q;
      fault_d  = fault_q;
      osr_d    = osr_q;
      cstart_d = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               if (beat_q < MSG_BEATS) begin
                  msg_d = (msg_q << W) | Y'(bus.msg_in[W-1:0]);
                  m1_d  = (m1_q << W) | Y'(bus.msg_in[2*W-1:W]);
                  m2_d  = (m2_q << W) | Y'(bus.msg_in[3*W-1:2*W]);
               end
               if (beat_q < RND_BEATS) begin
                  for (int n = 0; n < NR; n++) begin
                     rnd_d[n*RW +: RW] = (rnd_q[n*RW +: RW] << W) | RW'(bus.rnd_in[n*W +: W]);
                  end
               end
               if (beat_q < FLT_BEATS) begin
                  fault_d = (fault_q << W) | FL'(bus.fault_in);
               end
               if (beat_q == NB_LAST) begin
                  state_d = ARMED;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + CW'(1);
               end
            end
         end
         ARMED: begin
            if (bus.start) begin
               state_d  = RUN;
               cstart_d = 1'b1;
            end
         end
         RUN: begin
            if (bus.core_done) begin
               osr_d   = bus.core_hash;
               obeat_d = '0;
               state_d = UNLOAD;
            end
         end
         UNLOAD: begin
            // The digest leaves LSB slice first, so the shift register moves right.
            if (out_fire) begin
               osr_d = osr_q >> W;
               if (obeat_q == OUT_LAST) begin
                  state_d = LOAD;
                  obeat_d = '0;
               end else begin
                  obeat_d = obeat_q + OW'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
      in_ready_d = (state_d == LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD;
         beat_q     <= '0;
         obeat_q    <= '0;
         msg_q      <= '0;
         m1_q       <= '0;
         m2_q       <= '0;
         rnd_q      <= '0;
         fault_q    <= '0;
         osr_q      <= '0;
         in_ready_q <= 1'b0;
         cstart_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         obeat_q    <= obeat_d;
         msg_q      <= msg_d;
         m1_q       <= m1_d;
         m2_q       <= m2_d;
         rnd_q      <= rnd_d;
         fault_q    <= fault_d;
         osr_q      <= osr_d;
         in_ready_q <= in_ready_d;
         cstart_q   <= cstart_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.busy       = (state_q != LOAD);
   assign bus.core_msg   = msg_q;
   assign bus.core_m1    = m1_q;
   assign bus.core_m2    = m2_q;
   assign bus.core_rnd   = rnd_q;
   assign bus.core_fault = fault_q;
   assign bus.core_start = cstart_q;
   assign bus.out_valid  = (state_q == UNLOAD);
   assign bus.hash_out   = osr_q[W-1:0];
   assign bus.out_last   = (state_q == UNLOAD) && (obeat_q == OUT_LAST);
endmodule

// File: tb/tb_ascon_hash_sio.sv
// Bench for ascon_hash_sio: W=1 and W=8 instances, bench-side core model, operand and digest
// expectations derived from the stream layout (first beat = top slice in, LSB slice out first).
module tb_ascon_hash_sio;
   localparam int Y  = 40;
   localparam int L  = 256;
   localparam int RW = 64;
   localparam int NR = 7;
   localparam int FL = 256;

   typedef struct {
      logic [Y-1:0]  msg;
      logic [Y-1:0]  m1;
      logic [Y-1:0]  m2;
      logic [FL-1:0] fault;
      logic [L-1:0]  dig;
      int            mode;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [7:0] exp_q[$];

   logic [Y-1:0]     t_msg, t_m1, t_m2;
   logic [NR*RW-1:0] t_rnd;
   logic [FL-1:0]    t_fault;
   vec_t             tbl[3];

   always #5 clk = ~clk;

   ascon_hash_sio_if #(.W(1)) bus1 ();
   ascon_hash_sio_if #(.W(8)) bus8 ();

   ascon_hash_sio #(.W(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   ascon_hash_sio #(.W(8)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [447:0] act, input logic [447:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic rand_targets();
      logic [255:0] a;
      a = rand256(); t_msg = a[Y-1:0];
      a = rand256(); t_m1 = a[Y-1:0];
      a = rand256(); t_m2 = a[Y-1:0];
      t_fault = rand256();
      for (int i = 0; i < 14; i++) t_rnd[i*32 +: 32] = $urandom;
   endtask

   // Slice k of a len-bit value streamed MSB-first in w-bit beats; past the end it is junk.
   function automatic logic [7:0] sl(input logic [255:0] v, input int len, input int w, input int k);
      logic [7:0] r;
      r = 8'($urandom);
      if ((k + 1) * w <= len) begin
         for (int b = 0; b < w; b++) r[b] = v[len - (k + 1) * w + b];
      end
      return r;
   endfunction

   function automatic logic iready_of(input int wsel);
      return (wsel == 1) ? bus1.in_ready : bus8.in_ready;
   endfunction
   function automatic logic busy_of(input int wsel);
      return (wsel == 1) ? bus1.busy : bus8.busy;
   endfunction
   function automatic logic cstart_of(input int wsel);
      return (wsel == 1) ? bus1.core_start : bus8.core_start;
   endfunction
   function automatic logic ovalid_of(input int wsel);
      return (wsel == 1) ? bus1.out_valid : bus8.out_valid;
   endfunction
   function automatic logic olast_of(input int wsel);
      return (wsel == 1) ? bus1.out_last : bus8.out_last;
   endfunction
   function automatic logic [7:0] hout_of(input int wsel);
      return (wsel == 1) ? {7'b0, bus1.hash_out} : bus8.hash_out;
   endfunction

   task automatic set_start(input int wsel, input logic v);
      if (wsel == 1) bus1.start = v; else bus8.start = v;
   endtask
   task automatic set_done(input int wsel, input logic v, input logic [L-1:0] h);
      if (wsel == 1) begin bus1.core_done = v; bus1.core_hash = h; end
      else begin bus8.core_done = v; bus8.core_hash = h; end
   endtask
   task automatic set_oready(input int wsel, input logic v);
      if (wsel == 1) bus1.out_ready = v; else bus8.out_ready = v;
   endtask

   task automatic drive_beat(input int wsel, input int k, input logic iv);
      int w;
      logic [7:0] a, b, c, f;
      logic [7:0] r[NR];
      w = (wsel == 1) ? 1 : 8;
      a = sl(256'(t_msg), Y, w, k);
      b = sl(256'(t_m1), Y, w, k);
      c = sl(256'(t_m2), Y, w, k);
      f = sl(t_fault, FL, w, k);
      for (int n = 0; n < NR; n++) r[n] = sl(256'(t_rnd[n*RW +: RW]), RW, w, k);
      if (wsel == 1) begin
         bus1.in_valid = iv;
         bus1.msg_in   = {c[0], b[0], a[0]};
         bus1.fault_in = f[0];
         for (int n = 0; n < NR; n++) bus1.rnd_in[n] = r[n][0];
      end else begin
         bus8.in_valid = iv;
         bus8.msg_in   = {c, b, a};
         bus8.fault_in = f;
         for (int n = 0; n < NR; n++) bus8.rnd_in[n*8 +: 8] = r[n];
      end
   endtask

   // mode 0: always valid, 1: ~70% valid, 2: valid on alternate cycles.
   task automatic load(input int wsel, input int mode, input int stop_at, input int extra, output int acc);
      int cyc, post;
      logic iv, rdy;
      acc = 0; cyc = 0; post = 0;
      while (cyc < 4000 && !(acc >= stop_at && post >= extra)) begin
         if (acc >= stop_at) post++;
         case (mode)
            0:       iv = 1'b1;
            1:       iv = ($urandom_range(0, 99) < 70);
            default: iv = ((cyc % 2) == 0);
         endcase
         drive_beat(wsel, acc, iv);
         rdy = iready_of(wsel);
         tick();
         if (iv && rdy) acc++;
         cyc++;
      end
      drive_beat(wsel, 0, 1'b0);
   endtask

   task automatic check_ops(input int wsel);
      if (wsel == 1) begin
         check("core_msg", bus1.core_msg, t_msg);
         check("core_m1", bus1.core_m1, t_m1);
         check("core_m2", bus1.core_m2, t_m2);
         check("core_rnd", bus1.core_rnd, t_rnd);
         check("core_fault", bus1.core_fault, t_fault);
      end else begin
         check("w8_core_msg", bus8.core_msg, t_msg);
         check("w8_core_m1", bus8.core_m1, t_m1);
         check("w8_core_m2", bus8.core_m2, t_m2);
         check("w8_core_rnd", bus8.core_rnd, t_rnd);
         check("w8_core_fault", bus8.core_fault, t_fault);
      end
   endtask

   task automatic check_idle(input int wsel);
      check("idle_in_ready", iready_of(wsel), 0);
      check("idle_busy", busy_of(wsel), 0);
      check("idle_core_start", cstart_of(wsel), 0);
      check("idle_out_valid", ovalid_of(wsel), 0);
      check("idle_out_last", olast_of(wsel), 0);
      check("idle_hash_out", hout_of(wsel), 0);
      if (wsel == 1) begin
         check("idle_core_msg", bus1.core_msg, 0);
         check("idle_core_m1", bus1.core_m1, 0);
         check("idle_core_rnd", bus1.core_rnd, 0);
         check("idle_core_fault", bus1.core_fault, 0);
      end else begin
         check("idle_w8_core_msg", bus8.core_msg, 0);
         check("idle_w8_core_rnd", bus8.core_rnd, 0);
      end
   endtask

   // Runs ARMED -> RUN -> UNLOAD; rst_at >= 0 resets after that many digest beats.
   task automatic do_hash(input int wsel, input logic [L-1:0] dig, input int rst_at);
      int w, no, beats, cyc;
      logic ov, ol, orr;
      logic [7:0] ho, e;
      w = (wsel == 1) ? 1 : 8;
      no = L / w;
      set_done(wsel, 1'b1, ~dig);
      tick();
      set_done(wsel, 1'b0, '0);
      check("armed_ignores_done", ovalid_of(wsel), 0);
      check("armed_busy", busy_of(wsel), 1);
      set_start(wsel, 1'b1);
      tick();
      set_start(wsel, 1'b0);
      check("core_start_pulse", cstart_of(wsel), 1);
      tick();
      check("core_start_single", cstart_of(wsel), 0);
      repeat ($urandom_range(1, 4)) begin
         tick();
         check("run_no_out_valid", ovalid_of(wsel), 0);
      end
      set_done(wsel, 1'b1, dig);
      tick();
      set_done(wsel, 1'b0, rand256());
      check("out_valid_latency", ovalid_of(wsel), 1);
      for (int k = 0; k < no; k++) begin
         e = '0;
         for (int b = 0; b < w; b++) e[b] = dig[k * w + b];
         exp_q.push_back(e);
      end
      beats = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 4 * no + 50 && beats != rst_at) begin
         orr = 1'($urandom_range(0, 1));
         set_oready(wsel, orr);
         ov = ovalid_of(wsel);
         ho = hout_of(wsel);
         ol = olast_of(wsel);
         if (!ov) check("out_valid_held", ov, 1);
         tick();
         cyc++;
         if (ov && orr) begin
            e = exp_q.pop_front();
            check("hash_out", ho, e);
            check("out_last", ol, (beats == no - 1));
            beats++;
         end else if (ov) begin
            check("hold_hash_out", hout_of(wsel), ho);
            check("hold_out_last", olast_of(wsel), ol);
         end
      end
      set_oready(wsel, 1'b0);
      if (rst_at >= 0) begin
         check("unload_beats_before_rst", beats, rst_at);
         rst = 1'b1;
         tick();
         rst = 1'b0;
         exp_q.delete();
         check_idle(wsel);
         tick();
         check("ready_after_rst", iready_of(wsel), 1);
      end else begin
         check("digest_beats", beats, no);
         check("unload_exit_valid", ovalid_of(wsel), 0);
         check("unload_exit_busy", busy_of(wsel), 0);
         check("unload_exit_ready", iready_of(wsel), 1);
         check_ops(wsel);
         exp_q.delete();
      end
   endtask

   initial begin
      int acc;
      logic [255:0] a;
      bus1.in_valid = 0; bus1.msg_in = '0; bus1.rnd_in = '0; bus1.fault_in = '0;
      bus1.start = 0; bus1.core_hash = '0; bus1.core_done = 0; bus1.out_ready = 0;
      bus8.in_valid = 0; bus8.msg_in = '0; bus8.rnd_in = '0; bus8.fault_in = '0;
      bus8.start = 0; bus8.core_hash = '0; bus8.core_done = 0; bus8.out_ready = 0;

      tbl[0] = '{40'hA5A5A5A5A5, 40'h0123456789, 40'hFEDCBA9876, {8{32'hDEADBEEF}},
                 {4{64'h0123456789ABCDEF}}, 0};
      for (int i = 1; i < 3; i++) begin
         a = rand256(); tbl[i].msg = a[Y-1:0];
         a = rand256(); tbl[i].m1 = a[Y-1:0];
         a = rand256(); tbl[i].m2 = a[Y-1:0];
         tbl[i].fault = rand256();
         tbl[i].dig = rand256();
         tbl[i].mode = 1;
      end

      repeat (3) tick();
      rst = 1'b0;
      check_idle(1);
      check_idle(8);
      tick();
      check("ready_after_reset", iready_of(1), 1);

      set_start(1, 1'b1);
      repeat (3) begin
         tick();
         check("no_pulse_in_load", cstart_of(1), 0);
         check("load_not_busy", busy_of(1), 0);
      end
      set_start(1, 1'b0);

      // Back-to-back hashes without reset.
      for (int i = 0; i < 3; i++) begin
         t_msg = tbl[i].msg; t_m1 = tbl[i].m1; t_m2 = tbl[i].m2; t_fault = tbl[i].fault;
         for (int j = 0; j < 14; j++) t_rnd[j*32 +: 32] = $urandom;
         load(1, tbl[i].mode, 256, 0, acc);
         check("load_beats", acc, 256);
         check("ready_low_after_load", iready_of(1), 0);
         check("busy_armed", busy_of(1), 1);
         check_ops(1);
         do_hash(1, tbl[i].dig, -1);
      end

      // Reset at beat 100 of LOAD, then a fresh load aborted by reset in UNLOAD.
      rand_targets();
      load(1, 1, 100, 0, acc);
      check("partial_beats", acc, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle(1);
      tick();
      check("ready_after_mid_rst", iready_of(1), 1);
      rand_targets();
      load(1, 0, 256, 0, acc);
      check("reload_beats", acc, 256);
      check_ops(1);
      do_hash(1, rand256(), 50);
      rand_targets();
      load(1, 1, 256, 0, acc);
      check("post_rst_load_beats", acc, 256);
      check_ops(1);
      do_hash(1, rand256(), -1);

      // W=8: toggling in_valid, extra offered beats must not be taken.
      rand_targets();
      load(8, 2, 32, 20, acc);
      check("w8_load_beats", acc, 32);
      check("w8_ready_low", iready_of(8), 0);
      check_ops(8);
      do_hash(8, rand256(), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
